// File: rtl/vlog_stream_checker.sv
// Stream checker: queues expected words, compares them against the DUT output
// stream and emits one pass/fail result per testcase, with a stall watchdog.
module vlog_stream_checker #(
    parameter int DW      = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  logic [DW-1:0]            exp_data,
    input  logic                     exp_last,
    input  logic                     act_valid,
    output logic                     act_ready,
    input  logic [DW-1:0]            act_data,
    output logic                     res_valid,
    output logic                     res_ok,
    output logic                     res_timeout,
    output logic [15:0]              res_tc,
    output logic [15:0]              res_errors,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CHECK, FLUSH} state_t;

    state_t        state;
    logic [DW:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [SW-1:0] stall_cnt;
    logic [15:0]   err_cnt;
    logic [15:0]   err_next;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          act_hs;
    logic          flush_pop;
    logic          mismatch;
    logic          err_inc;
    logic          last_pop;
    logic          head_last;
    logic [DW-1:0] head_data;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign exp_ready = !full;
    assign act_ready = (state == CHECK) && !empty;
    assign level     = count;

    assign head_last = mem[rd_ptr][DW];
    assign head_data = mem[rd_ptr][DW-1:0];

    assign push      = exp_valid && !full;
    assign act_hs    = act_valid && act_ready;
    assign flush_pop = (state == FLUSH) && !empty;
    assign pop       = act_hs || flush_pop;
    assign last_pop  = pop && head_last;

    // Four-state inequality so an X/Z from the DUT is scored as a mismatch.
    assign mismatch  = act_hs && (act_data !== head_data);
    assign err_inc   = mismatch || flush_pop;
    assign err_next  = (err_inc && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + (AW+1)'(1);
        else if (pop && !push)
            count_next = count - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {exp_last, exp_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            stall_cnt   <= '0;
            err_cnt     <= '0;
            res_valid   <= 1'b0;
            res_ok      <= 1'b0;
            res_timeout <= 1'b0;
            res_tc      <= '0;
            res_errors  <= '0;
        end else begin
            count <= count_next;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            // The result reflects the word just popped, so err_next is used.
            res_valid <= last_pop;
            if (last_pop) begin
                res_errors  <= err_next;
                res_ok      <= (err_next == 16'd0) && !flush_pop;
                res_timeout <= flush_pop;
                res_tc      <= res_tc + 16'd1;
                err_cnt     <= '0;
            end else begin
                err_cnt     <= err_next;
            end

            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (count_next != '0)
                        state <= CHECK;
                end
                CHECK: begin
                    if (last_pop && (count_next == '0)) begin
                        state     <= IDLE;
                        stall_cnt <= '0;
                    end else if (act_hs || empty) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt == SW'(TIMEOUT - 1)) begin
                        state     <= FLUSH;
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + SW'(1);
                    end
                end
                FLUSH: begin
                    stall_cnt <= '0;
                    if (last_pop)
                        state <= (count_next == '0) ? IDLE : CHECK;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vlog_stream_checker.sv
// Scoreboard bench for vlog_stream_checker: one long-timeout instance for the
// functional tests and one short-timeout instance for the watchdog test.
module tb_vlog_stream_checker;

    typedef struct packed {
        logic        ok;
        logic        to;
        logic [15:0] tc;
        logic [15:0] errs;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_data = '0;
    logic        exp_last = 1'b0;
    logic        act_valid = 1'b0;
    logic [31:0] act_data = '0;

    logic        m_exp_valid, m_act_valid, w_exp_valid, w_act_valid;
    logic        m_exp_ready, m_act_ready, w_exp_ready, w_act_ready;
    logic        m_res_valid, m_res_ok, m_res_timeout;
    logic        w_res_valid, w_res_ok, w_res_timeout;
    logic [15:0] m_res_tc, m_res_errors, w_res_tc, w_res_errors;
    logic [4:0]  m_level, w_level;
    logic        cur_exp_ready, cur_act_ready;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    res_t sb_main[$];
    res_t sb_wd[$];
    int   pulse_cyc[$];
    res_t m_exp_r, w_exp_r;

    assign m_exp_valid   = exp_valid && !sel;
    assign m_act_valid   = act_valid && !sel;
    assign w_exp_valid   = exp_valid && sel;
    assign w_act_valid   = act_valid && sel;
    assign cur_exp_ready = sel ? w_exp_ready : m_exp_ready;
    assign cur_act_ready = sel ? w_act_ready : m_act_ready;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vlog_stream_checker #(.DW(32), .DEPTH(16), .TIMEOUT(64)) u_main (
        .clk(clk), .rst_n(rst_n),
        .exp_valid(m_exp_valid), .exp_ready(m_exp_ready), .exp_data(exp_data), .exp_last(exp_last),
        .act_valid(m_act_valid), .act_ready(m_act_ready), .act_data(act_data),
        .res_valid(m_res_valid), .res_ok(m_res_ok), .res_timeout(m_res_timeout),
        .res_tc(m_res_tc), .res_errors(m_res_errors), .level(m_level)
    );

    vlog_stream_checker #(.DW(32), .DEPTH(16), .TIMEOUT(8)) u_wd (
        .clk(clk), .rst_n(rst_n),
        .exp_valid(w_exp_valid), .exp_ready(w_exp_ready), .exp_data(exp_data), .exp_last(exp_last),
        .act_valid(w_act_valid), .act_ready(w_act_ready), .act_data(act_data),
        .res_valid(w_res_valid), .res_ok(w_res_ok), .res_timeout(w_res_timeout),
        .res_tc(w_res_tc), .res_errors(w_res_errors), .level(w_level)
    );

    function automatic res_t mkRes(input logic ok, input logic to, input int tc, input int errs);
        res_t r;
        r.ok   = ok;
        r.to   = to;
        r.tc   = 16'(tc);
        r.errs = 16'(errs);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitors pop the scoreboard on every result pulse; extra pulses are failures.
    always @(negedge clk) begin
        if (rst_n && m_res_valid) begin
            pulse_cyc.push_back(cyc);
            if (sb_main.size() == 0) begin
                checkOutput("main_unexpected_pulse", 64'd1, 64'd0);
            end else begin
                m_exp_r = sb_main.pop_front();
                checkOutput("main_result", {m_res_ok, m_res_timeout, m_res_tc, m_res_errors}, m_exp_r);
            end
        end
        if (rst_n && w_res_valid) begin
            if (sb_wd.size() == 0) begin
                checkOutput("wd_unexpected_pulse", 64'd1, 64'd0);
            end else begin
                w_exp_r = sb_wd.pop_front();
                checkOutput("wd_result", {w_res_ok, w_res_timeout, w_res_tc, w_res_errors}, w_exp_r);
            end
        end
    end

    task automatic pushExp(input logic [31:0] d, input logic last);
        int n = 0;
        exp_valid = 1'b1;
        exp_data  = d;
        exp_last  = last;
        while (!cur_exp_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cur_exp_ready)
            checkOutput("exp_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        exp_valid = 1'b0;
    endtask

    task automatic sendAct(input logic [31:0] d);
        int n = 0;
        act_valid = 1'b1;
        act_data  = d;
        while (!cur_act_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cur_act_ready)
            checkOutput("act_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        act_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] ew[4], input logic [31:0] aw[4], input int n, input res_t r);
        sb_main.push_back(r);
        for (int i = 0; i < n; i++)
            pushExp(ew[i], (i == n - 1));
        for (int i = 0; i < n; i++)
            sendAct(aw[i]);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((sb_main.size() + sb_wd.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 64'(sb_main.size() + sb_wd.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] ew[4];
        logic [31:0] aw[4];

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_exp_ready", m_exp_ready, 1);
        checkOutput("rst_act_ready", m_act_ready, 0);
        checkOutput("rst_res_valid", m_res_valid, 0);
        checkOutput("rst_res_ok", m_res_ok, 0);
        checkOutput("rst_res_timeout", m_res_timeout, 0);
        checkOutput("rst_res_tc", m_res_tc, 0);
        checkOutput("rst_res_errors", m_res_errors, 0);
        checkOutput("rst_level", m_level, 0);

        ew = '{32'd1, 32'd2, 32'd3, 32'd0};
        aw = '{32'd1, 32'd2, 32'd3, 32'd0};
        applyStimulus(ew, aw, 3, mkRes(1, 0, 1, 0));
        waitDrain("t1_drain");
        repeat (3) @(negedge clk);
        checkOutput("t1_hold_tc", m_res_tc, 1);
        checkOutput("t1_hold_ok", m_res_ok, 1);

        ew = '{32'hA5, 32'h5A, 32'd0, 32'd0};
        aw = '{32'hA5, 32'h00, 32'd0, 32'd0};
        applyStimulus(ew, aw, 2, mkRes(0, 0, 2, 1));
        waitDrain("t2_drain");

        // Fill to full, then exercise pop-only, push+pop and push-only cycles.
        sb_main.push_back(mkRes(1, 0, 3, 0));
        sb_main.push_back(mkRes(1, 0, 4, 0));
        for (int i = 0; i < 16; i++)
            pushExp(32'h100 + i, (i == 15));
        exp_valid = 1'b1;
        exp_data  = 32'h200;
        exp_last  = 1'b0;
        checkOutput("t3_full_exp_ready", m_exp_ready, 0);
        checkOutput("t3_full_level", m_level, 16);
        act_valid = 1'b1;
        act_data  = 32'h100;
        @(negedge clk);
        checkOutput("t3_level_after_pop", m_level, 15);
        act_data  = 32'h101;
        @(negedge clk);
        checkOutput("t3_level_push_pop", m_level, 15);
        act_valid = 1'b0;
        exp_data  = 32'h201;
        exp_last  = 1'b1;
        @(negedge clk);
        exp_valid = 1'b0;
        checkOutput("t3_level_refill", m_level, 16);
        for (int i = 2; i < 16; i++)
            sendAct(32'h100 + i);
        sendAct(32'h200);
        sendAct(32'h201);
        waitDrain("t3_drain");

        sel = 1'b1;
        sb_wd.push_back(mkRes(0, 1, 1, 2));
        pushExp(32'd7, 1'b0);
        pushExp(32'd8, 1'b0);
        pushExp(32'd9, 1'b1);
        sendAct(32'd7);
        waitDrain("t4_drain");
        checkOutput("t4_level", w_level, 0);
        sel = 1'b0;

        pushExp(32'h11, 1'b0);
        pushExp(32'h22, 1'b1);
        sendAct(32'h11);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("t5_level", m_level, 0);
        checkOutput("t5_res_tc", m_res_tc, 0);
        checkOutput("t5_res_valid", m_res_valid, 0);
        ew = '{32'h33, 32'd0, 32'd0, 32'd0};
        aw = '{32'h33, 32'd0, 32'd0, 32'd0};
        applyStimulus(ew, aw, 1, mkRes(1, 0, 1, 0));
        waitDrain("t5_drain");

        pulse_cyc.delete();
        sb_main.push_back(mkRes(1, 0, 2, 0));
        sb_main.push_back(mkRes(1, 0, 3, 0));
        pushExp(32'h44, 1'b1);
        pushExp(32'h55, 1'b1);
        sendAct(32'h44);
        sendAct(32'h55);
        waitDrain("t6_drain");
        checkOutput("t6_pulse_count", 64'(pulse_cyc.size()), 64'd2);
        if (pulse_cyc.size() == 2)
            checkOutput("t6_pulse_gap", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
